oam_sprite_scanner: RTL
=======================

Name: oam_sprite_scanner

Overview:
- Per-scanline OAM search stage; sits directly upstream of the whizgraphics pixel renderer.
- At the start of each line it walks all 40 OAM entries and selects, in OAM order, the first MAX_SPRITES entries whose vertical extent covers the current line.
- Stores the selections in a small slot buffer. The renderer reads the buffer while it draws the line.

Parameters:
- NUM_OBJECTS, 40, number of OAM entries scanned per line.
- MAX_SPRITES, 10, capacity of the slot buffer (per-line sprite limit).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse requesting a scan of line `line`.
- line  input  8  current LY value; sampled on the start edge.
- tall_sprites  input  1  LCDC sprite size: 0 = 8x8, 1 = 8x16; sampled on the start edge.
- sprite_enable  input  1  LCDC sprite enable; sampled on the start edge.
- oam_addr  output  6  OAM entry index being read (registered).
- oam_y  input  8  entry Y byte. Valid the cycle after oam_addr is presented (synchronous RAM).
- oam_x  input  8  entry X byte, same timing as oam_y.
- busy  output  1  scan in progress.
- done  output  1  one-cycle pulse at scan completion.
- count  output  4  number of valid slots, 0..MAX_SPRITES.
- rd_slot  input  4  slot select for the renderer.
- rd_index  output  6  OAM index held in the selected slot.
- rd_x  output  8  X byte held in the selected slot.
- rd_row  output  4  row within the sprite for this line, 0..15.

Behaviour:
- Reset values: busy=0, done=0, count=0, oam_addr=0, state IDLE. Slot contents are don't-care.
- States: IDLE -> SCAN -> DONE -> IDLE.
- IDLE:
  - start=1 at edge E0 latches line, tall_sprites and sprite_enable.
  - Clears count, sets oam_addr=0, busy=1, moves to SCAN.
- SCAN:
  - oam_addr increments by 1 each edge, up to NUM_OBJECTS-1, then holds.
  - Entry k is presented on oam_addr after edge E(k). Its data is evaluated at edge E(k+2).
  - Entry NUM_OBJECTS-1 is evaluated at E41. The same edge moves to DONE.
- DONE:
  - done=1 and busy=0 for exactly the one cycle following E41.
  - Returns to IDLE on the next edge.
  - Total scan time from the start edge to done is fixed at 41 clocks, regardless of hits.
- Hit test, computed with 9-bit unsigned arithmetic:
  - L = line + 16; H = 16 if tall else 8.
  - Hit iff L >= oam_y and L < oam_y + H.
  - Row = (L - oam_y)[3:0].
- On a hit:
  - If sprite_enable=1 and count < MAX_SPRITES, write {index k, oam_x, row} into slot[count] and increment count.
  - Otherwise discard the hit.
- Oam_x does not affect selection: X=0 and X>=168 entries still consume a slot.
- Slot order is ascending OAM index.
- Read port is combinational:
  - rd_slot < count: return the slot contents.
  - Otherwise (including any slot >= MAX_SPRITES): return all zeros.
- Count is held after done until the next accepted start, so the renderer reads stable data for the whole line.
- Start while busy or in DONE is ignored: no restart, latched values unchanged.
- Reset mid-scan forces the reset values immediately at that edge. done does not pulse for the aborted scan.
- Line values >= 144 are legal; the hit test is applied unchanged.

Test Plan:
- Single hit: entry 0 Y=26 X=40, all other entries Y=0; line=10, 8x8, enabled.
  - done exactly 41 clocks after start; count=1.
  - slot0: index=0, x=40, row=0.
  - rd_slot=1 returns zeros.
- Overflow: entries 0..11 Y=16, line=0.
  - count=10; slots 0..9 hold index 0..9, row 0.
  - Entries 10 and 11 absent.
  - done still at clock 41.
- Tall sprites: entry 5 Y=16, line=15.
  - tall=1: count=1, index=5, row=15.
  - Repeat with tall=0: count=0.
- Boundaries, 8x8:
  - Y=0, line=0: no hit.
  - Y=152, line=143: hit, row=7.
  - Y=160, line=143: no hit.
  - Y=9, line=0: hit, row=7.
  - Y=8, line=0: no hit.
- Reset mid-scan: pulse reset at clock 20 of a 3-hit scan.
  - busy=0, count=0, oam_addr=0 next cycle; no done.
  - A new start yields the full 3-hit result.
- Ignored start and disable:
  - Start pulsed at clock 10 of a scan: done still at clock 41 of the original scan.
  - sprite_enable=0 with matching entries: scan completes in 41 clocks with count=0.

Source files
------------

// File: rtl/oam_sprite_scanner.sv
// ---------------------------------------------------------------------------
// oam_sprite_scanner
//
// Per-scanline OAM search. On a start pulse the block walks all OAM entries
// in index order and keeps the first MAX_SPRITES entries whose vertical
// extent covers the requested line. The pixel renderer reads the selected
// entries back through a combinational slot read port while it draws.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   start           one-cycle scan request; samples line/tall_sprites/
//                   sprite_enable on the same edge
//   line            current LY value
//   tall_sprites    0 = 8x8 sprites, 1 = 8x16 sprites
//   sprite_enable   when 0 the scan runs but stores nothing
//   oam_addr        registered OAM entry index driven to the OAM RAM
//   oam_y, oam_x    OAM entry bytes, valid one cycle after oam_addr
//   busy            scan in progress
//   done            one-cycle pulse when the scan has finished
//   count           number of valid slots
//   rd_slot         renderer slot select
//   rd_index        OAM index held in the selected slot (0 if invalid)
//   rd_x            X byte held in the selected slot (0 if invalid)
//   rd_row          sprite row for this line (0 if invalid)
// ---------------------------------------------------------------------------
module oam_sprite_scanner #(
    parameter int NUM_OBJECTS = 40,
    parameter int MAX_SPRITES = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] line,
    input  logic       tall_sprites,
    input  logic       sprite_enable,
    output logic [5:0] oam_addr,
    input  logic [7:0] oam_y,
    input  logic [7:0] oam_x,
    output logic       busy,
    output logic       done,
    output logic [3:0] count,
    input  logic [3:0] rd_slot,
    output logic [5:0] rd_index,
    output logic [7:0] rd_x,
    output logic [3:0] rd_row
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] oam_addr_q, oam_addr_d;
    logic [5:0] cyc_q, cyc_d;          // edges seen since the start edge, minus one
    logic [3:0] count_q, count_d;
    logic [7:0] line_q, line_d;
    logic       tall_q, tall_d;
    logic       en_q, en_d;

    // Slot buffer: written one entry at a time in OAM order, read
    // combinationally by the renderer.
    logic [5:0] slot_index_q [MAX_SPRITES];
    logic [7:0] slot_x_q     [MAX_SPRITES];
    logic [3:0] slot_row_q   [MAX_SPRITES];

    // Evaluation pipeline. Entry k is addressed after edge E(k), its data
    // arrives after E(k+1) and is judged at E(k+2). cyc_q holds n-1 before
    // edge E(n), so the entry under evaluation is cyc_q-1.
    logic       eval_valid;
    logic [5:0] eval_index;
    logic [8:0] l_ext;
    logic [8:0] y_ext;
    logic [8:0] h_ext;
    logic       hit;
    logic [3:0] hit_row;
    logic       wr_en;

    always_comb begin
        eval_valid = (state_q == ST_SCAN) && (cyc_q != 6'd0);
        eval_index = cyc_q - 6'd1;
        l_ext      = {1'b0, line_q} + 9'd16;
        y_ext      = {1'b0, oam_y};
        h_ext      = tall_q ? 9'd16 : 9'd8;
        hit        = (l_ext >= y_ext) && (l_ext < (y_ext + h_ext));
        // Low four bits of (L - Y) only depend on the low four bits of each.
        hit_row    = l_ext[3:0] - oam_y[3:0];
        wr_en      = eval_valid && hit && en_q && (count_q < 4'(MAX_SPRITES));
    end

    always_comb begin
        state_d    = state_q;
        oam_addr_d = oam_addr_q;
        cyc_d      = cyc_q;
        count_d    = count_q;
        line_d     = line_q;
        tall_d     = tall_q;
        en_d       = en_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    line_d     = line;
                    tall_d     = tall_sprites;
                    en_d       = sprite_enable;
                    count_d    = 4'd0;
                    oam_addr_d = 6'd0;
                    cyc_d      = 6'd0;
                    state_d    = ST_SCAN;
                end
            end
            ST_SCAN: begin
                cyc_d = cyc_q + 6'd1;
                if (oam_addr_q < 6'(NUM_OBJECTS - 1)) begin
                    oam_addr_d = oam_addr_q + 6'd1;
                end
                if (wr_en) begin
                    count_d = count_q + 4'd1;
                end
                // The last entry is judged on this edge; finish here.
                if (cyc_q == 6'(NUM_OBJECTS)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            oam_addr_q <= 6'd0;
            cyc_q      <= 6'd0;
            count_q    <= 4'd0;
            line_q     <= 8'd0;
            tall_q     <= 1'b0;
            en_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            oam_addr_q <= oam_addr_d;
            cyc_q      <= cyc_d;
            count_q    <= count_d;
            line_q     <= line_d;
            tall_q     <= tall_d;
            en_q       <= en_d;
        end
    end

    // Slot contents need no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            slot_index_q[count_q] <= eval_index;
            slot_x_q[count_q]     <= oam_x;
            slot_row_q[count_q]   <= hit_row;
        end
    end

    always_comb begin
        rd_index = 6'd0;
        rd_x     = 8'd0;
        rd_row   = 4'd0;
        // count never exceeds MAX_SPRITES, so this also blocks
        // out-of-range slot selects.
        if (rd_slot < count_q) begin
            rd_index = slot_index_q[rd_slot];
            rd_x     = slot_x_q[rd_slot];
            rd_row   = slot_row_q[rd_slot];
        end
    end

    assign oam_addr = oam_addr_q;
    assign count    = count_q;
    assign busy     = (state_q == ST_SCAN);
    assign done     = (state_q == ST_DONE);

endmodule
